// File: rtl/multi_pulse_sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_pulse_sync_pkg                                                        |
// | Shared edge-mode encodings, filter FSM states and edge-match helper.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package multi_pulse_sync_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_QUAL   = 1'b1
  } filt_state_e;

  // True when an accepted transition to new_level is one the channel reports.
  function automatic logic edge_match(input logic [1:0] mode, input logic new_level);
    logic hit;
    case (mode)
      EDGE_RISE: hit = new_level;
      EDGE_FALL: hit = ~new_level;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_pulse_sync_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_pulse_sync_if                                                         |
// | Config, input and status bundle; count signals only with                    |
// | MULTI_PULSE_SYNC_COUNT_EN defined.                                          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface multi_pulse_sync_if #(
  parameter int N_CH   = 8,
  parameter int FILT_W = 8,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 16
);

  logic [N_CH-1:0]   in;
  logic [1:0]        edge_mode;
  logic [FILT_W-1:0] n_filter_cycles;
  logic [HOLD_W-1:0] n_holdoff_cycles;
  logic              missed_clr;
  logic [N_CH-1:0]   out;
  logic [N_CH-1:0]   level_out;
  logic [N_CH-1:0]   missed;
`ifdef MULTI_PULSE_SYNC_COUNT_EN
  logic                  count_clr;
  logic [N_CH*CNT_W-1:0] count;
`endif

  modport master (
    output in, edge_mode, n_filter_cycles, n_holdoff_cycles, missed_clr,
`ifdef MULTI_PULSE_SYNC_COUNT_EN
    output count_clr,
    input  count,
`endif
    input  out, level_out, missed
  );

  modport slave (
    input  in, edge_mode, n_filter_cycles, n_holdoff_cycles, missed_clr,
`ifdef MULTI_PULSE_SYNC_COUNT_EN
    input  count_clr,
    output count,
`endif
    output out, level_out, missed
  );

endinterface
`default_nettype wire

// File: rtl/multi_pulse_sync_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_pulse_sync_chan                                                       |
// | One channel: synchronizer, glitch filter, edge select, holdoff, missed flag |
// | and (MULTI_PULSE_SYNC_COUNT_EN) saturating pulse counter.                   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module multi_pulse_sync_chan
  import multi_pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int HOLD_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_async,
  input  logic [1:0]        edge_mode,
  input  logic [FILT_W-1:0] n_filter_cycles,
  input  logic [HOLD_W-1:0] n_holdoff_cycles,
  input  logic              missed_clr,
`ifdef MULTI_PULSE_SYNC_COUNT_EN
  input  logic              count_clr,
  output logic [CNT_W-1:0]  count,
`endif
  output logic              out,
  output logic              level_out,
  output logic              missed
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  filt_state_e       state_q, state_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q, level_d;
  logic              out_q, out_d;
  logic              missed_q, missed_d;
  logic              sync_s;
  logic              accept;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_async};
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      state_q    <= ST_STABLE;
      filt_cnt_q <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      out_q      <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      filt_cnt_q <= filt_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      out_q      <= out_d;
      missed_q   <= missed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    level_d    = level_q;
    out_d      = 1'b0;
    missed_d   = missed_q;
    hold_cnt_d = hold_cnt_q;
    accept     = 1'b0;

    if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - 1'b1;
    if (missed_clr)       missed_d   = 1'b0;

    case (state_q)
      ST_STABLE: begin
        filt_cnt_d = '0;
        if (sync_s != level_q) state_d = ST_QUAL;
      end
      ST_QUAL: begin
        if (sync_s == level_q) begin
          state_d    = ST_STABLE;
          filt_cnt_d = '0;
        end else if (filt_cnt_q >= n_filter_cycles) begin
          // >= rather than == so a threshold lowered mid-qualification still ends it
          level_d    = sync_s;
          accept     = 1'b1;
          state_d    = ST_STABLE;
          filt_cnt_d = '0;
        end else begin
          filt_cnt_d = filt_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_STABLE;
        filt_cnt_d = '0;
      end
    endcase

    // A matching edge inside holdoff is flagged; the set overrides a same-cycle clear.
    if (accept && edge_match(edge_mode, sync_s)) begin
      if (hold_cnt_q == '0) begin
        out_d      = 1'b1;
        hold_cnt_d = n_holdoff_cycles;
      end else begin
        missed_d   = 1'b1;
      end
    end
  end

  assign out       = out_q;
  assign level_out = level_q;
  assign missed    = missed_q;

`ifdef MULTI_PULSE_SYNC_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (count_clr)
      count_d = out_d ? CNT_W'(1) : '0;
    else if (out_d && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  assign count = count_q;
`endif

endmodule
`default_nettype wire

// File: rtl/multi_pulse_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_pulse_sync                                                            |
// | N_CH independent async pulse/level capture channels; per-channel counters   |
// | packed ch0-in-LSBs when MULTI_PULSE_SYNC_COUNT_EN is defined.               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module multi_pulse_sync
  import multi_pulse_sync_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8,
  parameter int HOLD_W      = 8,
  parameter int CNT_W       = 16
) (
  input logic             clk,
  input logic             rst,
  multi_pulse_sync_if.slave bus
);

  logic [N_CH-1:0] out_w;
  logic [N_CH-1:0] level_w;
  logic [N_CH-1:0] missed_w;
`ifdef MULTI_PULSE_SYNC_COUNT_EN
  logic [N_CH*CNT_W-1:0] count_w;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    multi_pulse_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W),
      .HOLD_W      (HOLD_W),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk              (clk),
      .rst              (rst),
      .in_async         (bus.in[i]),
      .edge_mode        (bus.edge_mode),
      .n_filter_cycles  (bus.n_filter_cycles),
      .n_holdoff_cycles (bus.n_holdoff_cycles),
      .missed_clr       (bus.missed_clr),
`ifdef MULTI_PULSE_SYNC_COUNT_EN
      .count_clr        (bus.count_clr),
      .count            (count_w[i*CNT_W +: CNT_W]),
`endif
      .out              (out_w[i]),
      .level_out        (level_w[i]),
      .missed           (missed_w[i])
    );
  end

  assign bus.out       = out_w;
  assign bus.level_out = level_w;
  assign bus.missed    = missed_w;
`ifdef MULTI_PULSE_SYNC_COUNT_EN
  assign bus.count     = count_w;
`endif

endmodule
`default_nettype wire
